// File: rtl/btn_debounce_pulse.sv
// Pushbutton conditioner: two-flop synchronizer, four-state debounce FSM,
// single-cycle press strobe with optional hold auto-repeat, registered level.
module btn_debounce_pulse #(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_raw,
  output logic btn_pulse,
  output logic btn_level
);

  localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit REP_EN = (REPEAT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic sync_p0, sync_p1;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic pulse_d, level_d;

  function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] v);
    return (v == DB_LAST) ? v : v + DB_W'(1);
  endfunction

  function automatic logic [REP_W-1:0] rep_inc(input logic [REP_W-1:0] v);
    return (v == REP_LAST) ? v : v + REP_W'(1);
  endfunction

  // Stage p0/p1: metastability synchronizer; only sync_p1 feeds the FSM
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    case (state_q)
      IDLE: begin
        if (sync_p1) begin
          state_d  = CONFIRM_PRESS;
          db_cnt_d = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!sync_p1) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_inc(db_cnt_q);
        end
      end
      HELD: begin
        if (!sync_p1) begin
          state_d  = CONFIRM_RELEASE;
          db_cnt_d = '0;
        end
      end
      CONFIRM_RELEASE: begin
        if (sync_p1) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_inc(db_cnt_q);
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  // Repeat terminal count is held through CONFIRM_RELEASE and fires once back in HELD;
  // the !btn_pulse guard keeps strobes from ever landing on adjacent cycles.
  always_comb begin
    pulse_d   = 1'b0;
    rep_cnt_d = rep_cnt_q;
    level_d   = (state_d == HELD) || (state_d == CONFIRM_RELEASE);
    if (state_q == CONFIRM_PRESS && state_d == HELD) begin
      pulse_d   = 1'b1;
      rep_cnt_d = '0;
    end else if (REP_EN && (state_q == HELD || state_q == CONFIRM_RELEASE)) begin
      if (rep_cnt_q == REP_LAST) begin
        if (state_q == HELD && !btn_pulse) begin
          pulse_d   = 1'b1;
          rep_cnt_d = '0;
        end
      end else begin
        rep_cnt_d = rep_inc(rep_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      db_cnt_q  <= '0;
      rep_cnt_q <= '0;
      btn_pulse <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      btn_pulse <= pulse_d;
      btn_level <= level_d;
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with DB_CYCLES=4: one instance without
// auto-repeat and one with REPEAT_CYCLES=8, both on the same stimulus.
module tb_btn_debounce_pulse;

  logic clk;
  logic clr_n;
  logic btn_raw;
  logic pulse0, level0, pulse1, level1;

  btn_debounce_pulse #(.DB_CYCLES(4), .REPEAT_CYCLES(0)) dut (
    .clk(clk), .clr_n(clr_n), .btn_raw(btn_raw),
    .btn_pulse(pulse0), .btn_level(level0)
  );

  btn_debounce_pulse #(.DB_CYCLES(4), .REPEAT_CYCLES(8)) dut_rep (
    .clk(clk), .clr_n(clr_n), .btn_raw(btn_raw),
    .btn_pulse(pulse1), .btn_level(level1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit p0_log [64];
  bit l0_log [64];
  bit p1_log [64];
  int n_p0, n_p1, first_p0, first_p1, low0;
  int b2b = 0;
  bit prev_p0 = 1'b0;
  bit prev_p1 = 1'b0;

  // downstream counter stage fed by the press strobes
  int chain_cnt0 = 0;
  int chain_cnt1 = 0;
  always_ff @(posedge clk) begin
    if (pulse0) chain_cnt0 <= chain_cnt0 + 1;
    if (pulse1) chain_cnt1 <= chain_cnt1 + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge; index i = edge Ei.
  task automatic run(input int n);
    n_p0 = 0; n_p1 = 0; first_p0 = 0; first_p1 = 0; low0 = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      p0_log[i] = pulse0;
      l0_log[i] = level0;
      p1_log[i] = pulse1;
      if (pulse0) begin
        n_p0++;
        if (first_p0 == 0) first_p0 = i;
      end
      if (pulse1) begin
        n_p1++;
        if (first_p1 == 0) first_p1 = i;
      end
      if (!level0) low0++;
      if ((pulse0 && prev_p0) || (pulse1 && prev_p1)) b2b++;
      prev_p0 = pulse0;
      prev_p1 = pulse1;
    end
  endtask

  int tmp_p0, tmp_low, c0, c1;

  initial begin
    clk     = 1'b0;
    clr_n   = 1'b1;
    btn_raw = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    check("reset_pulse", pulse0, 0);
    check("reset_level", level0, 0);
    run(3);
    check("reset_hold_level", level1, 0);
    clr_n = 1'b1;
    run(4);
    check("post_reset_quiet_pulse", n_p0 + n_p1, 0);
    check("post_reset_quiet_level", low0, 4);

    // clean press
    btn_raw = 1'b1;
    run(20);
    check("press_first_pulse", first_p0, 7);
    check("press_pulse_count", n_p0, 1);
    check("press_level_e6", l0_log[6], 0);
    check("press_level_e7", l0_log[7], 1);
    check("press_level_e20", l0_log[20], 1);
    check("press_rep_first", first_p1, 7);
    check("press_rep_e15", p1_log[15], 1);
    check("press_rep_count", n_p1, 2);

    // clean release
    btn_raw = 1'b0;
    run(20);
    check("release_level_e6", l0_log[6], 1);
    check("release_level_e7", l0_log[7], 0);
    check("release_pulse_count", n_p0, 0);

    // bounce 1,0,1,1,0 then steady 1 from edge 6
    btn_raw = 1'b1; run(1);
    btn_raw = 1'b0; run(1);
    btn_raw = 1'b1; run(2);
    btn_raw = 1'b0; run(1);
    check("bounce_no_pulse_tail", n_p0, 0);
    btn_raw = 1'b1;
    run(15);
    check("bounce_first_pulse", first_p0, 7);
    check("bounce_pulse_count", n_p0, 1);

    // short release glitch while held
    btn_raw = 1'b0;
    run(2);
    tmp_p0 = n_p0; tmp_low = low0;
    btn_raw = 1'b1;
    run(10);
    check("glitch_no_pulse", tmp_p0 + n_p0, 0);
    check("glitch_level_kept", tmp_low + low0, 0);

    // long release
    btn_raw = 1'b0;
    run(20);
    check("long_release_e6", l0_log[6], 1);
    check("long_release_e7", l0_log[7], 0);
    check("long_release_pulse", n_p0, 0);

    // auto-repeat held 40 cycles
    btn_raw = 1'b1;
    run(40);
    check("repeat_count", n_p1, 5);
    check("repeat_first", first_p1, 7);
    check("repeat_e38", p1_log[38], 0);
    check("repeat_e39", p1_log[39], 1);
    check("no_repeat_count", n_p0, 1);

    // asynchronous reset mid-hold
    clr_n = 1'b0;
    #1;
    check("async_level0", level0, 0);
    check("async_level1", level1, 0);
    run(3);
    clr_n = 1'b1;
    run(20);
    check("rst_hold_quiet_e1", p0_log[1] + l0_log[1], 0);
    check("rst_hold_level_e6", l0_log[6], 0);
    check("rst_hold_first_pulse", first_p0, 7);
    check("rst_hold_pulse_count", n_p0, 1);
    check("rst_hold_rep_first", first_p1, 7);

    // reset mid-debounce discards progress
    btn_raw = 1'b0;
    run(10);
    btn_raw = 1'b1;
    run(5);
    tmp_p0 = n_p0;
    clr_n = 1'b0;
    run(2);
    clr_n = 1'b1;
    btn_raw = 1'b0;
    run(12);
    check("rst_debounce_no_pulse", tmp_p0 + n_p0 + n_p1, 0);

    // five presses into the downstream counter
    c0 = chain_cnt0;
    c1 = chain_cnt1;
    for (int k = 0; k < 5; k++) begin
      btn_raw = 1'b1;
      run(10);
      btn_raw = 1'b0;
      run(10);
    end
    check("chain_steps", chain_cnt0 - c0, 5);
    check("chain_steps_rep", chain_cnt1 - c1, 5);

    check("no_back_to_back", b2b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
